ddr_sample_ctrl: RTL and testbench

Phase-selection and word-assembly controller for a DDR input sampler. Each clkn cycle it consumes a sample pair (q0 = earlier sample, q1 = later sample) from the sampler and classifies where the data transitions fall. It then locks onto the sample phase farther from the transitions and assembles the selected bit stream into WORD_W-bit words with a valid/ready handshake. It also detects loss of lock and re-hunts automatically.

---
 rtl/ddr_sample_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_ddr_sample_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ddr_sample_ctrl.sv
// ddr_sample_ctrl -- phase selection and word assembly for a DDR input sampler.
//
// Every clkn cycle a sample pair (q0 earlier, q1 later) arrives. The controller
// classifies where the data transitions fall:
//   mid = q0 ^ q1       (transition between the two samples of a pair)
//   bnd = prev_q1 ^ q0  (transition across the pair boundary)
// HUNT counts both classes and locks onto the phase farther from the dominant
// class. LOCKED shifts the selected bit into WORD_W-bit words (MSB first),
// offers them on a valid/ready register, and drops back to HUNT once the net
// count of wrong-class transitions reaches LOSS_CNT.
//
// Ports:
//   clkn, _rst       clock, asynchronous active-low reset
//   en               enable; low returns to IDLE
//   q0, q1           sample pair for this cycle
//   sel              phase in use (0 = q0, 1 = q1)
//   locked           high while in LOCKED
//   word_data/valid  assembled word and its valid flag
//   word_ready       consumer accept
//   overflow/ovf_clr sticky dropped-word flag and its synchronous clear
//
// Optional macro DDR_CTRL_STATS_EN adds word_cnt (accepted transfers) and
// relock_cnt (LOCKED->HUNT drops); both saturate and are cleared by ovf_clr.
module ddr_sample_ctrl #(
   parameter int WORD_W   = 8,
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 8
) (
   input  logic              clkn,
   input  logic              _rst,
   input  logic              en,
   input  logic              q0,
   input  logic              q1,
   output logic              sel,
   output logic              locked,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              overflow,
   input  logic              ovf_clr
`ifdef DDR_CTRL_STATS_EN
   ,
   output logic [15:0]       word_cnt,
   output logic [7:0]        relock_cnt
`endif
);

   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);
   localparam int BW = $clog2(WORD_W);
   localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_CNT);
   localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_CNT);
   localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

   typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic              prev_q1_q;
   logic [CW-1:0]     mid_cnt_q, mid_cnt_d, bnd_cnt_q, bnd_cnt_d;
   logic [LW-1:0]     loss_cnt_q, loss_cnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] word_data_q, word_data_d;
   logic              word_valid_q, word_valid_d;
   logic              overflow_q, overflow_d;

   logic              mid, bnd, sbit, exp_t, opp_t;
   logic              word_done, lost, ovf_set, xfer;
   logic [CW-1:0]     mid_inc, bnd_inc;
   logic [LW-1:0]     loss_nxt;
   logic [WORD_W-1:0] done_word;

   assign mid   = q0 ^ q1;
   assign bnd   = prev_q1_q ^ q0;
   assign sbit  = sel_q ? q1 : q0;
   // Locked on q0 means data edges sit mid-pair; on q1 they sit at the boundary.
   assign exp_t = sel_q ? bnd : mid;
   assign opp_t = sel_q ? mid : bnd;
   assign xfer  = word_valid_q & word_ready;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      mid_cnt_d  = mid_cnt_q;
      bnd_cnt_d  = bnd_cnt_q;
      loss_cnt_d = loss_cnt_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      word_done  = 1'b0;
      lost       = 1'b0;
      done_word  = {shift_q[WORD_W-2:0], sbit};
      mid_inc    = (mid && mid_cnt_q != LOCK_MAX) ? mid_cnt_q + CW'(1) : mid_cnt_q;
      bnd_inc    = (bnd && bnd_cnt_q != LOCK_MAX) ? bnd_cnt_q + CW'(1) : bnd_cnt_q;
      loss_nxt   = loss_cnt_q;
      if (opp_t && !exp_t)
         loss_nxt = loss_cnt_q + LW'(1);
      else if (exp_t && !opp_t && loss_cnt_q != '0)
         loss_nxt = loss_cnt_q - LW'(1);

      if (!en) begin
         state_d    = IDLE;
         mid_cnt_d  = '0;
         bnd_cnt_d  = '0;
         loss_cnt_d = '0;
         shift_d    = '0;
         bit_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               mid_cnt_d = '0;
               bnd_cnt_d = '0;
               shift_d   = '0;
               bit_cnt_d = '0;
               state_d   = HUNT;
            end
            HUNT: begin
               mid_cnt_d = mid_inc;
               bnd_cnt_d = bnd_inc;
               // mid wins a tie: check it first
               if (mid_inc == LOCK_MAX) begin
                  state_d = LOCKED;
                  sel_d   = 1'b0;
               end else if (bnd_inc == LOCK_MAX) begin
                  state_d = LOCKED;
                  sel_d   = 1'b1;
               end
            end
            LOCKED: begin
               shift_d = done_word;
               if (bit_cnt_q == BIT_LAST) begin
                  word_done = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
               loss_cnt_d = loss_nxt;
               if (loss_nxt == LOSS_MAX) begin
                  lost       = 1'b1;
                  state_d    = HUNT;
                  loss_cnt_d = '0;
                  shift_d    = '0;
                  bit_cnt_d  = '0;
                  mid_cnt_d  = '0;
                  bnd_cnt_d  = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output register: accept and a fresh word on the same edge reload with no bubble.
   always_comb begin
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      ovf_set      = 1'b0;
      if (word_done) begin
         if (!word_valid_q || word_ready) begin
            word_data_d  = done_word;
            word_valid_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end else if (xfer) begin
         word_valid_d = 1'b0;
      end
      overflow_d = ovf_set | (overflow_q & ~ovf_clr);
   end

   always_ff @(posedge clkn or negedge _rst) begin
      if (!_rst) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         prev_q1_q    <= 1'b0;
         mid_cnt_q    <= '0;
         bnd_cnt_q    <= '0;
         loss_cnt_q   <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         prev_q1_q    <= q1;
         mid_cnt_q    <= mid_cnt_d;
         bnd_cnt_q    <= bnd_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   assign sel        = sel_q;
   assign locked     = (state_q == LOCKED);
   assign word_data  = word_data_q;
   assign word_valid = word_valid_q;
   assign overflow   = overflow_q;

`ifdef DDR_CTRL_STATS_EN
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [7:0]  relock_cnt_q, relock_cnt_d;

   always_comb begin
      word_cnt_d   = word_cnt_q;
      relock_cnt_d = relock_cnt_q;
      if (ovf_clr) begin
         word_cnt_d   = '0;
         relock_cnt_d = '0;
      end else begin
         if (xfer && word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
         if (lost && relock_cnt_q != 8'hFF)  relock_cnt_d = relock_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clkn or negedge _rst) begin
      if (!_rst) begin
         word_cnt_q   <= '0;
         relock_cnt_q <= '0;
      end else begin
         word_cnt_q   <= word_cnt_d;
         relock_cnt_q <= relock_cnt_d;
      end
   end

   assign word_cnt   = word_cnt_q;
   assign relock_cnt = relock_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_sample_ctrl.sv
// Directed bench for ddr_sample_ctrl (WORD_W=8, LOCK_CNT=4, LOSS_CNT=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_ddr_sample_ctrl;
   logic       clkn = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, q0 = 1'b0, q1 = 1'b0;
   logic       word_ready = 1'b1, ovf_clr = 1'b0;
   logic       sel, locked, word_valid, overflow;
   logic [7:0] word_data;
`ifdef DDR_CTRL_STATS_EN
   logic [15:0] word_cnt;
   logic [7:0]  relock_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clkn = ~clkn;

   ddr_sample_ctrl #(.WORD_W(8), .LOCK_CNT(4), .LOSS_CNT(8)) dut (
      .clkn(clkn), ._rst(rst_n), .en(en), .q0(q0), .q1(q1),
      .sel(sel), .locked(locked), .word_data(word_data), .word_valid(word_valid),
      .word_ready(word_ready), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef DDR_CTRL_STATS_EN
      , .word_cnt(word_cnt), .relock_cnt(relock_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic a, input logic b);
      q0 = a;
      q1 = b;
      @(posedge clkn);
      #1;
   endtask

   // (b, ~b): mid transition every pair, so q0-locked loss tracking never grows
   task automatic send_bit(input logic b);
      step(b, ~b);
   endtask

   task automatic send_bits(input logic [7:0] w, input int first, input int last);
      for (int i = first; i <= last; i++) send_bit(w[7-i]);
   endtask

   initial begin
      logic [7:0] a5, x3c, x0f, xc3;
      a5 = 8'hA5; x3c = 8'h3C; x0f = 8'h0F; xc3 = 8'hC3;

      #2;
      chk("rst_sel", sel, 0);
      chk("rst_locked", locked, 0);
      chk("rst_data", word_data, 0);
      chk("rst_valid", word_valid, 0);
      chk("rst_ovf", overflow, 0);
      @(posedge clkn); #1;
      rst_n = 1'b1;

      // Boundary-class lock: IDLE->HUNT, then four bnd transitions
      en = 1'b1;
      step(0, 0);
      step(0, 0); step(1, 1); step(0, 0); step(1, 1);
      chk("bnd3_unlocked", locked, 0);
      step(0, 0);
      chk("bnd_locked", locked, 1);
      chk("bnd_sel", sel, 1);

      // Loss with sel=1: one quiet bit, then mid-only pairs; word 0x55 completes on 7th
      step(0, 0);
      for (int i = 0; i < 7; i++) step(i[0], ~i[0]);
      chk("w55_valid", word_valid, 1);
      chk("w55_data", word_data, 32'h55);
      chk("loss7_locked", locked, 1);
      step(1, 0);
      chk("loss_locked", locked, 0);
      chk("loss_valid", word_valid, 0);
      chk("loss_sel_hold", sel, 1);
`ifdef DDR_CTRL_STATS_EN
      chk("relock_cnt", relock_cnt, 1);
      chk("word_cnt_a", word_cnt, 1);
`endif

      // Tie-break lock: prev_q1=1 before the (0,1) pairs makes mid and bnd both count
      en = 1'b0;
      step(1, 1);
      chk("en_off_locked", locked, 0);
      en = 1'b1;
      step(1, 1);
      step(0, 1); step(0, 1); step(0, 1);
      chk("tie3_unlocked", locked, 0);
      step(0, 1);
      chk("tie_locked", locked, 1);
      chk("tie_sel", sel, 0);

      // Word 0xA5 with ready=1, cleared on next edge
      send_bits(a5, 0, 6);
      chk("a5_pre_valid", word_valid, 0);
      send_bits(a5, 7, 7);
      chk("a5_valid", word_valid, 1);
      chk("a5_data", word_data, 32'hA5);
      send_bits(a5, 0, 0);
      chk("a5_clr_valid", word_valid, 0);

      // ready low across two words: second dropped, overflow set
      word_ready = 1'b0;
      send_bits(a5, 1, 7);
      chk("a5b_valid", word_valid, 1);
      chk("a5b_ovf", overflow, 0);
      send_bits(x3c, 0, 7);
      chk("ovf_data", word_data, 32'hA5);
      chk("ovf_set", overflow, 1);
      ovf_clr = 1'b1;
      send_bits(x0f, 0, 0);
      ovf_clr = 1'b0;
      chk("ovf_clr", overflow, 0);
      chk("ovf_clr_data", word_data, 32'hA5);
`ifdef DDR_CTRL_STATS_EN
      chk("stat_clr_word", word_cnt, 0);
      chk("stat_clr_relock", relock_cnt, 0);
`endif

      // Accept and complete on the same edge: no bubble
      send_bits(x0f, 1, 6);
      chk("hold_data", word_data, 32'hA5);
      word_ready = 1'b1;
      send_bits(x0f, 7, 7);
      chk("same_edge_valid", word_valid, 1);
      chk("same_edge_data", word_data, 32'h0F);
      send_bits(xc3, 0, 0);
      chk("0f_taken", word_valid, 0);
`ifdef DDR_CTRL_STATS_EN
      chk("word_cnt_b", word_cnt, 2);
`endif

      // Drop en after 3 bits: no word, then relock and the next word starts fresh
      send_bits(xc3, 1, 2);
      en = 1'b0;
      step(1, 1);
      chk("en_drop_locked", locked, 0);
      for (int i = 0; i < 6; i++) step(1, 0);
      chk("en_drop_valid", word_valid, 0);
      en = 1'b1;
      step(1, 1);
      step(0, 1); step(0, 1); step(0, 1); step(0, 1);
      chk("relock", locked, 1);
      send_bits(xc3, 0, 6);
      chk("c3_pre_valid", word_valid, 0);
      send_bits(xc3, 7, 7);
      chk("c3_data", word_data, 32'hC3);
      chk("c3_valid", word_valid, 1);

      // Async reset mid-word and mid-handshake
      word_ready = 1'b0;
      send_bits(xc3, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", word_valid, 0);
      chk("arst_data", word_data, 0);
      chk("arst_locked", locked, 0);
      chk("arst_sel", sel, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
